// File: rtl/kernel_cc_label_min_reduce.sv
// Collapses runs of equal vertex ids from the candidate-label FIFO into one
// {vertex, min_label} record per run, under a start/done job handshake.
module kernel_cc_label_min_reduce #(
  parameter int ID_WIDTH  = 32,
  parameter int CNT_WIDTH = 32
) (
  input  logic                  clk,
  input  logic                  reset_n,
  input  logic                  start,
  input  logic [CNT_WIDTH-1:0]  num_records,
  output logic                  busy,
  output logic                  done,
  input  logic                  in_empty_n,
  output logic                  in_read,
  input  logic [2*ID_WIDTH-1:0] in_dout,
  input  logic                  out_full_n,
  output logic                  out_write,
  output logic [2*ID_WIDTH-1:0] out_din,
  output logic [CNT_WIDTH-1:0]  groups_emitted
);

  typedef enum logic [2:0] {IDLE, RUN, FLUSH, DRAIN, DONE} state_t;

  state_t                state, nxt;
  logic [CNT_WIDTH-1:0]  remaining;
  logic [ID_WIDTH-1:0]   cur_vid, cur_min;
  logic                  have_cur;
  logic [2*ID_WIDTH-1:0] hold;
  logic                  hold_valid;

  logic [ID_WIDTH-1:0] vid, label;
  logic                same_vid, hold_free;

  assign vid       = in_dout[2*ID_WIDTH-1:ID_WIDTH];
  assign label     = in_dout[ID_WIDTH-1:0];
  assign same_vid  = (vid == cur_vid);
  // hold can take a new group if empty or being drained this cycle
  assign hold_free = !hold_valid || out_full_n;

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) state <= IDLE;
    else          state <= nxt;
  end

  always_comb begin
    nxt = state;
    case (state)
      IDLE:  if (start) nxt = (num_records == '0) ? DONE : RUN;
      RUN:   if (remaining == '0) nxt = FLUSH;
      FLUSH: if (!hold_valid || out_write) nxt = DRAIN;
      DRAIN: if (!hold_valid || out_write) nxt = DONE;
      DONE:  nxt = IDLE;
      default: nxt = IDLE;
    endcase
  end

  always_comb begin
    busy      = (state != IDLE);
    done      = (state == DONE);
    out_write = hold_valid && out_full_n;
    out_din   = hold;
    in_read   = (state == RUN) && in_empty_n && (remaining != '0) &&
                (!have_cur || same_vid || hold_free);
  end

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      remaining      <= '0;
      cur_vid        <= '0;
      cur_min        <= '0;
      have_cur       <= 1'b0;
      hold           <= '0;
      hold_valid     <= 1'b0;
      groups_emitted <= '0;
    end else begin
      if (out_write) begin
        hold_valid     <= 1'b0;
        groups_emitted <= groups_emitted + 1'b1;
      end
      case (state)
        IDLE: if (start) begin
          remaining      <= num_records;
          groups_emitted <= '0;
          have_cur       <= 1'b0;
        end
        RUN: if (in_read) begin
          remaining <= remaining - 1'b1;
          if (!have_cur) begin
            cur_vid  <= vid;
            cur_min  <= label;
            have_cur <= 1'b1;
          end else if (same_vid) begin
            if (label < cur_min) cur_min <= label;
          end else begin
            // group boundary: retire current run into hold, start the next
            hold       <= {cur_vid, cur_min};
            hold_valid <= 1'b1;
            cur_vid    <= vid;
            cur_min    <= label;
          end
        end
        FLUSH: if (!hold_valid || out_write) begin
          hold       <= {cur_vid, cur_min};
          hold_valid <= 1'b1;
          have_cur   <= 1'b0;
        end
        default: ;
      endcase
    end
  end

endmodule

// File: tb/tb_kernel_cc_label_min_reduce.sv
// Bench for kernel_cc_label_min_reduce: FIFO models on both sides, run-length
// min reference computed from the record list, directed plus random jobs.
module tb_kernel_cc_label_min_reduce;
  logic        clk = 0;
  logic        reset_n = 0;
  logic        start = 0;
  logic [31:0] num_records = 0;
  logic        busy, done, in_empty_n, in_read, out_full_n, out_write;
  logic [63:0] in_dout, out_din;
  logic [31:0] groups_emitted;

  kernel_cc_label_min_reduce dut (
    .clk(clk), .reset_n(reset_n), .start(start), .num_records(num_records),
    .busy(busy), .done(done), .in_empty_n(in_empty_n), .in_read(in_read),
    .in_dout(in_dout), .out_full_n(out_full_n), .out_write(out_write),
    .out_din(out_din), .groups_emitted(groups_emitted)
  );

  always #5 clk = ~clk;

  int          checks = 0, errors = 0;
  logic [63:0] src[$], got[$], exp_q[$];
  int          in_mode = 0;     // 0 always ready, 1 toggle, 2 random
  bit          out_rand = 0;
  int          stall_cnt = 0;
  bit          tog = 0, pop_pend = 0;
  int          pops = 0, dones = 0, viol = 0, cyc = 0, pop_first = -1, pop_last = -1;

  task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] expv);
    checks++;
    assert (obs === expv) else begin
      errors++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, expv);
    end
  endtask

  // upstream/downstream FIFO stand-ins, updated just after each rising edge
  initial begin
    in_empty_n = 0; in_dout = 0; out_full_n = 1;
    forever begin
      @(posedge clk); #1;
      if (pop_pend && src.size() > 0) void'(src.pop_front());
      pop_pend = 0;
      tog = ~tog;
      in_empty_n = (src.size() > 0) &&
                   (in_mode == 0 ? 1'b1 : in_mode == 1 ? tog : ($urandom_range(0, 3) != 0));
      in_dout    = (src.size() > 0) ? src[0] : 64'h0;
      out_full_n = (stall_cnt == 0) && (!out_rand || $urandom_range(0, 3) != 0);
      if (stall_cnt > 0) stall_cnt--;
    end
  end

  initial forever begin
    @(negedge clk);
    cyc++;
    if (in_read && !in_empty_n) viol++;
    if (out_write && !out_full_n) viol++;
    if (in_read) begin
      pops++;
      if (pop_first < 0) pop_first = cyc;
      pop_last = cyc;
      pop_pend = 1;
    end
    if (out_write) got.push_back(out_din);
    if (done) dones++;
  end

  // Reference: each maximal run of equal vertex ids yields {vid, min label}
  function automatic void model(input logic [63:0] recs[$]);
    exp_q.delete();
    foreach (recs[i]) begin
      if (i == 0 || recs[i][63:32] != recs[i-1][63:32]) exp_q.push_back(recs[i]);
      else if (recs[i][31:0] < exp_q[$][31:0]) exp_q[$][31:0] = recs[i][31:0];
    end
  endfunction

  task automatic run_job(input string tag, input int n, input bit mid_start, output int waited);
    bit seen = 0;
    model(src);
    got.delete(); pops = 0; dones = 0; viol = 0; pop_first = -1; pop_last = -1;
    @(posedge clk); #1 start = 1; num_records = n;
    @(posedge clk); #1 start = 0;
    if (mid_start) begin
      repeat (2) @(posedge clk);
      #1 start = 1; num_records = 1;
      @(posedge clk); #1 start = 0;
    end
    waited = 0;
    while (!seen && waited < 3000) begin
      @(negedge clk); waited++;
      seen = done;
    end
    chk({tag, "_done_seen"}, seen, 1);
    repeat (2) @(negedge clk);
    chk({tag, "_done_once"}, dones, 1);
    chk({tag, "_busy"}, busy, 0);
    chk({tag, "_pops"}, pops, n);
    chk({tag, "_groups"}, groups_emitted, exp_q.size());
    chk({tag, "_nout"}, got.size(), exp_q.size());
    foreach (exp_q[i]) chk($sformatf("%s_out%0d", tag, i), (i < got.size()) ? got[i] : 64'hx, exp_q[i]);
    chk({tag, "_proto"}, viol, 0);
  endtask

  initial begin
    int w, n;
    logic [31:0] v;
    repeat (3) @(negedge clk);
    chk("rst_busy", busy, 0);   chk("rst_done", done, 0);
    chk("rst_read", in_read, 0); chk("rst_write", out_write, 0);
    chk("rst_din", out_din, 0); chk("rst_groups", groups_emitted, 0);
    reset_n = 1;

    // 1: basic grouping, no bubbles
    src = '{64'h7_00000009, 64'h7_00000003, 64'h7_00000005, 64'h8_00000004, 64'h8_00000004};
    run_job("t1", 5, 0, w);
    chk("t1_g0", got.size() > 0 ? got[0] : 64'hx, 64'h00000007_00000003);
    chk("t1_g1", got.size() > 1 ? got[1] : 64'hx, 64'h00000008_00000004);
    chk("t1_b2b", pop_last - pop_first, 4);

    // 2: empty job
    run_job("t2", 0, 0, w);
    chk("t2_lat", w <= 2, 1);

    // 3: downstream stall blocks only the second boundary
    src = '{64'h1_0000000A, 64'h2_00000014, 64'h3_0000001E};
    stall_cnt = 12;
    fork
      run_job("t3", 3, 0, w);
      begin
        repeat (7) @(negedge clk);
        chk("t3_stall_pops", pops, 2);
        chk("t3_stall_read", in_read, 0);
      end
    join

    // 4: full-width ids, unsigned compare
    src = '{64'hFFFFFFFF_FFFFFFFF, 64'hFFFFFFFF_00000000};
    run_job("t4", 2, 0, w);
    chk("t4_g0", got.size() > 0 ? got[0] : 64'hx, 64'hFFFFFFFF_00000000);

    // 5: bursty upstream
    in_mode = 1;
    src = '{64'h42_00000050, 64'h42_00000011, 64'h42_00000090, 64'h42_00000012};
    run_job("t5", 4, 0, w);
    in_mode = 0;

    // 6: asynchronous reset mid-job, then a clean job
    src = '{64'h5_00000001, 64'h6_00000002, 64'h7_00000003, 64'h8_00000004};
    pops = 0;
    @(posedge clk); #1 start = 1; num_records = 4;
    @(posedge clk); #1 start = 0;
    for (int i = 0; i < 50 && pops < 2; i++) @(negedge clk);
    @(posedge clk); #3 reset_n = 0;
    #1;
    chk("t6_busy", busy, 0);   chk("t6_write", out_write, 0);
    chk("t6_read", in_read, 0); chk("t6_din", out_din, 0);
    chk("t6_groups", groups_emitted, 0);
    src.delete();
    @(negedge clk); reset_n = 1;
    src = '{64'h9_00000030, 64'h9_00000020, 64'hA_00000001};
    run_job("t6b", 3, 0, w);

    // random jobs, including a start pulse while busy and repeated vertices
    for (int j = 0; j < 8; j++) begin
      n = $urandom_range(1, 20);
      v = $urandom_range(0, 3);
      for (int k = 0; k < n; k++) begin
        if ($urandom_range(0, 2) == 0) v = $urandom_range(0, 3);
        src.push_back({v, 32'($urandom)});
      end
      in_mode  = $urandom_range(0, 2);
      out_rand = $urandom_range(0, 1);
      run_job($sformatf("rnd%0d", j), n, j[0], w);
    end

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end
endmodule
